truth_table_scanner: RTL

- Sequential reader for the combinational minterm/maxterm blocks: sweeps every input combination of an N-input function under test, waits a settle window, samples the function output and assembles the measured truth table.
- Compares the measured table against an expected table, reporting a mismatch count and the first failing minterm index.
- Sits beside a function-under-test instance as an on-chip replacement for hand-written exhaustive stimulus benches.

---
 rtl/truth_table_scanner_pkg.sv | 21 ++
 rtl/truth_table_scanner_if.sv | 32 +++
 rtl/truth_table_scanner_tt_settle_timer.sv | 29 ++
 rtl/truth_table_scanner.sv | 134 +++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and width helpers for the truth-table scanner.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FINISH
  } state_t;

  // Truth-table width for an n-input function.
  function automatic int unsigned tbl_w(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Mismatch counter width; one extra bit so a fully wrong table (2**n) fits.
  function automatic int unsigned cnt_w(input int unsigned n_in);
    return n_in + 32'd1;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bundle between the scanner, its controller and the function under test.
interface truth_table_scanner_if
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned TBL_W = tbl_w(N_IN);
  localparam int unsigned CNT_W = cnt_w(N_IN);

  logic               start;
  logic [TBL_W-1:0]   expected;
  logic [N_IN-1:0]    stim;
  logic               dut_out;
  logic               busy;
  logic               done;
  logic [TBL_W-1:0]   table_out;
  logic [CNT_W-1:0]   mismatch_cnt;
  logic [N_IN-1:0]    first_fail;
  logic               pass;

  // Controller / function-under-test side.
  modport master (
    output start, expected, dut_out,
    input  stim, busy, done, table_out, mismatch_cnt, first_fail, pass
  );

  // Scanner side.
  modport slave (
    input  start, expected, dut_out,
    output stim, busy, done, table_out, mismatch_cnt, first_fail, pass
  );
endinterface

// File: rtl/truth_table_scanner_tt_settle_timer.sv
// Per-vector hold counter: cleared by load, counts while enabled, and flags
// the cycle on which the hold window has elapsed.
module tt_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic term
);
  // With SETTLE==0 the scanner never enters HOLD, so the terminal value is moot.
  localparam logic [3:0] LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  logic [3:0] cnt_q;

  // Counter register: load wins over count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= 4'd0;
    end else if (en) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign term = (cnt_q == LAST);
endmodule

// File: rtl/truth_table_scanner.sv
// Exhaustive sweep of an N_IN-input function: drives every vector, holds it
// SETTLE+1 cycles, samples the output, and compares against an expected table.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_scanner_if.slave  bus
);
  localparam int unsigned TBL_W = tbl_w(N_IN);
  localparam int unsigned CNT_W = cnt_w(N_IN);
  localparam logic [N_IN-1:0] LAST_STIM = {N_IN{1'b1}};
  // Vector that follows a sample; skip HOLD entirely when there is no settle.
  localparam state_t AFTER_LOAD = (SETTLE == 0) ? SAMPLE : HOLD;

  state_t             state_q, state_d;
  logic [TBL_W-1:0]   exp_q, exp_d;
  logic [N_IN-1:0]    stim_q, stim_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [CNT_W-1:0]   mm_q, mm_d;
  logic [N_IN-1:0]    ff_q, ff_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tmr_load, tmr_en, tmr_term;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .term  (tmr_term)
  );

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      stim_q  <= '0;
      table_q <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      stim_q  <= stim_d;
      table_q <= table_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, table capture and compare.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    stim_d   = stim_q;
    table_d  = table_q;
    mm_d     = mm_q;
    ff_d     = ff_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d    = bus.expected;
          stim_d   = '0;
          table_d  = '0;
          mm_d     = '0;
          ff_d     = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = AFTER_LOAD;
        end
      end
      HOLD: begin
        if (tmr_term) begin
          state_d = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SAMPLE: begin
        table_d[stim_q] = bus.dut_out;
        if (bus.dut_out != exp_q[stim_q]) begin
          mm_d = mm_q + CNT_W'(1);
          // Count still zero means this is the first miss of the scan.
          if (mm_q == '0) begin
            ff_d = stim_q;
          end
        end
        if (stim_q == LAST_STIM) begin
          state_d = FINISH;
        end else begin
          stim_d   = stim_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = AFTER_LOAD;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (mm_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim         = stim_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mm_q;
  assign bus.first_fail   = ff_q;
  assign bus.pass         = pass_q;
endmodule
